// File: rtl/jtframe_sdram_sched.sv
// SDRAM request scheduler: one transaction at a time from four bank ports or the download port.
// Define JTFRAME_SDRAM_RR_EN for round-robin bank arbitration; otherwise bank 0 has fixed top priority.
`timescale 1ns/1ps
module jtframe_sdram_sched #(
  parameter int AW   = 22,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ba,
  input  logic          prog_rd,
  input  logic          prog_we,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  output logic          prog_ack,
  output logic          prog_rdy,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  input  logic          ba_wr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_rdy,
  output logic          cmd_req,
  output logic [1:0]    cmd_ba,
  output logic [AW-1:0] cmd_addr,
  output logic          cmd_wr,
  output logic [15:0]   cmd_din,
  output logic [1:0]    cmd_mask,
  input  logic          cmd_ack,
  input  logic          cmd_done,
  output logic          tout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [2:0] OWN_PROG  = 3'd4;
  localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

  state_t        state_q, state_d;
  logic [2:0]    owner_q, owner_d;
  logic          cmd_req_q, cmd_req_d;
  logic [1:0]    cmd_ba_q, cmd_ba_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [15:0]   cmd_din_q, cmd_din_d;
  logic [1:0]    cmd_mask_q, cmd_mask_d;
  logic [3:0]    ba_ack_q, ba_ack_d;
  logic [3:0]    ba_rdy_q, ba_rdy_d;
  logic          prog_ack_q, prog_ack_d;
  logic          prog_rdy_q, prog_rdy_d;
  logic          tout_err_q, tout_err_d;
  logic [7:0]    wdog_q, wdog_d;

  logic [3:0]    bank_req;
  logic [3:0]    req_rot;
  logic [1:0]    search_base;
  logic          bank_hit;
  logic [1:0]    bank_off;
  logic [1:0]    bank_win;
  logic [AW-1:0] bank_addr;
  logic          ack_own;
  logic          rdy_own;

  assign bank_req = ba_rd | {3'b000, ba_wr};

`ifdef JTFRAME_SDRAM_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] req_dbl;

  // Rotate the request vector so the search always scans from bit 0 upward.
  always_comb begin
    req_dbl     = {bank_req, bank_req} >> ptr_q;
    req_rot     = req_dbl[3:0];
    search_base = ptr_q;
  end
`else
  always_comb begin
    req_rot     = bank_req;
    search_base = 2'd0;
  end
`endif

  always_comb begin
    bank_hit = 1'b0;
    bank_off = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!bank_hit && req_rot[i]) begin
        bank_hit = 1'b1;
        bank_off = 2'(i);
      end
    end
    bank_win = search_base + bank_off;
  end

  always_comb begin
    unique case (bank_win)
      2'd0:    bank_addr = ba0_addr;
      2'd1:    bank_addr = ba1_addr;
      2'd2:    bank_addr = ba2_addr;
      default: bank_addr = ba3_addr;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cmd_req_d  = cmd_req_q;
    cmd_ba_d   = cmd_ba_q;
    cmd_addr_d = cmd_addr_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_din_d  = cmd_din_q;
    cmd_mask_d = cmd_mask_q;
    wdog_d     = wdog_q;
    ba_ack_d   = '0;
    ba_rdy_d   = '0;
    prog_ack_d = 1'b0;
    prog_rdy_d = 1'b0;
    tout_err_d = 1'b0;
    ack_own    = 1'b0;
    rdy_own    = 1'b0;
`ifdef JTFRAME_SDRAM_RR_EN
    ptr_d      = ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (downloading) begin
          if (prog_rd || prog_we) begin
            owner_d    = OWN_PROG;
            cmd_ba_d   = prog_ba;
            cmd_addr_d = prog_addr;
            cmd_wr_d   = prog_we;
            cmd_din_d  = prog_data;
            cmd_mask_d = prog_mask;
            cmd_req_d  = 1'b1;
            state_d    = ISSUE;
          end
        end else if (bank_hit) begin
          owner_d    = {1'b0, bank_win};
          cmd_ba_d   = bank_win;
          cmd_addr_d = bank_addr;
          cmd_wr_d   = (bank_win == 2'd0) && ba_wr;
          cmd_din_d  = ba0_din;
          cmd_mask_d = ba0_din_m;
          cmd_req_d  = 1'b1;
          state_d    = ISSUE;
`ifdef JTFRAME_SDRAM_RR_EN
          ptr_d      = bank_win + 2'd1;
`endif
        end
      end
      ISSUE: begin
        if (cmd_ack) begin
          cmd_req_d = 1'b0;
          ack_own   = 1'b1;
          if (cmd_done) begin
            rdy_own = 1'b1;
            state_d = IDLE;
          end else begin
            wdog_d  = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cmd_done) begin
          rdy_own = 1'b1;
          state_d = IDLE;
        end else if (wdog_q == TOUT_LAST) begin
          tout_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ack_own) begin
      if (owner_q == OWN_PROG) prog_ack_d = 1'b1;
      else ba_ack_d[owner_q[1:0]] = 1'b1;
    end
    if (rdy_own) begin
      if (owner_q == OWN_PROG) prog_rdy_d = 1'b1;
      else ba_rdy_d[owner_q[1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      cmd_req_q  <= 1'b0;
      cmd_ba_q   <= '0;
      cmd_addr_q <= '0;
      cmd_wr_q   <= 1'b0;
      cmd_din_q  <= '0;
      cmd_mask_q <= '0;
      wdog_q     <= '0;
      ba_ack_q   <= '0;
      ba_rdy_q   <= '0;
      prog_ack_q <= 1'b0;
      prog_rdy_q <= 1'b0;
      tout_err_q <= 1'b0;
`ifdef JTFRAME_SDRAM_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cmd_req_q  <= cmd_req_d;
      cmd_ba_q   <= cmd_ba_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_din_q  <= cmd_din_d;
      cmd_mask_q <= cmd_mask_d;
      wdog_q     <= wdog_d;
      ba_ack_q   <= ba_ack_d;
      ba_rdy_q   <= ba_rdy_d;
      prog_ack_q <= prog_ack_d;
      prog_rdy_q <= prog_rdy_d;
      tout_err_q <= tout_err_d;
`ifdef JTFRAME_SDRAM_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign cmd_req  = cmd_req_q;
  assign cmd_ba   = cmd_ba_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_wr   = cmd_wr_q;
  assign cmd_din  = cmd_din_q;
  assign cmd_mask = cmd_mask_q;
  assign ba_ack   = ba_ack_q;
  assign ba_rdy   = ba_rdy_q;
  assign prog_ack = prog_ack_q;
  assign prog_rdy = prog_rdy_q;
  assign tout_err = tout_err_q;

endmodule

// File: tb/tb_jtframe_sdram_sched.sv
// Scoreboard bench for jtframe_sdram_sched: a request model predicts grants, a monitor checks the DUT.
`timescale 1ns/1ps
module tb_jtframe_sdram_sched;

  localparam int AW   = 22;
  localparam int TOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          downloading;
  logic [AW-1:0] prog_addr;
  logic [1:0]    prog_ba;
  logic          prog_rd, prog_we;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_ack, prog_rdy;
  logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]    ba_rd;
  logic          ba_wr;
  logic [15:0]   ba0_din;
  logic [1:0]    ba0_din_m;
  logic [3:0]    ba_ack, ba_rdy;
  logic          cmd_req;
  logic [1:0]    cmd_ba;
  logic [AW-1:0] cmd_addr;
  logic          cmd_wr;
  logic [15:0]   cmd_din;
  logic [1:0]    cmd_mask;
  logic          cmd_ack  = 1'b0;
  logic          cmd_done = 1'b0;
  logic          tout_err;

  jtframe_sdram_sched #(.AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_rd(prog_rd), .prog_we(prog_we),
    .prog_data(prog_data), .prog_mask(prog_mask), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .cmd_req(cmd_req), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .cmd_wr(cmd_wr),
    .cmd_din(cmd_din), .cmd_mask(cmd_mask), .cmd_ack(cmd_ack), .cmd_done(cmd_done),
    .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            owner;
    logic [1:0]    ba;
    logic [AW-1:0] addr;
    bit            wr;
    logic [15:0]   din;
    logic [1:0]    mask;
    bit            tout;
    longint        ack_cyc;
  } txn_t;

  txn_t   exp_q[$];
  txn_t   act_q[$];
  txn_t   done_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     ptr_m = 0;

  int m_ack_dly  = 0;
  int m_done_dly = 0;
  bit m_sim      = 1'b0;
  bit m_hang     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference arbitration: which requester the scheduler should serve next.
  function automatic int pick();
    int b;
    if (downloading) return (prog_rd || prog_we) ? 4 : -1;
    for (int k = 0; k < 4; k++) begin
`ifdef JTFRAME_SDRAM_RR_EN
      b = (ptr_m + k) % 4;
`else
      b = k;
`endif
      if (ba_rd[b] || (b == 0 && ba_wr)) return b;
    end
    return -1;
  endfunction

  task automatic push_exp(input int w);
    txn_t e;
    e.owner = w;
    if (w == 4) begin
      e.ba = prog_ba; e.addr = prog_addr; e.wr = prog_we;
      e.din = prog_data; e.mask = prog_mask;
    end else begin
      e.ba = w[1:0];
      case (w)
        0:       e.addr = ba0_addr;
        1:       e.addr = ba1_addr;
        2:       e.addr = ba2_addr;
        default: e.addr = ba3_addr;
      endcase
      e.wr = (w == 0) && ba_wr;
      e.din = ba0_din; e.mask = ba0_din_m;
      ptr_m = (w + 1) % 4;
    end
    e.tout = !m_sim && m_hang;
    e.ack_cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic drop(input int w);
    if (w == 4) begin
      prog_rd = 1'b0; prog_we = 1'b0;
    end else begin
      ba_rd[w] = 1'b0;
      if (w == 0) ba_wr = 1'b0;
    end
  endtask

  task automatic clear_lines();
    ba_rd = '0; ba_wr = 1'b0; prog_rd = 1'b0; prog_we = 1'b0;
  endtask

  task automatic set_engine(input int ad, input int dd, input bit sim, input bit hang);
    m_ack_dly = ad; m_done_dly = dd; m_sim = sim; m_hang = hang;
  endtask

  // Serve pending requests in model order; keep=1 leaves lines high after ack.
  task automatic serve(input int max_g, input bit keep, input bit lat);
    int w;
    int n;
    bit got;
    n = 0;
    while (n < max_g) begin
      w = pick();
      if (w < 0) break;
      push_exp(w);
      if (lat && n == 0) begin
        @(posedge clk); #1;
        chk("req_latency", 64'(cmd_req), 64'd1);
      end
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(posedge clk); #1;
        if (ba_ack != 4'd0 || prog_ack) got = 1'b1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL ack_timeout actual=none required=ack_for_%0d", w);
        break;
      end
      n++;
      if (!keep) drop(w);
      else if (n == max_g) clear_lines();
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(posedge clk); #1;
      ok = (exp_q.size() == 0) && (act_q.size() == 0) && (done_q.size() == 0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout actual=exp%0d_act%0d_done%0d required=all_empty",
               exp_q.size(), act_q.size(), done_q.size());
    end
  endtask

  task automatic flush_model();
    exp_q.delete(); act_q.delete(); done_q.delete(); ptr_m = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_cmd"}, 64'({cmd_req, cmd_ba, cmd_addr, cmd_wr, cmd_din, cmd_mask}), 64'd0);
    chk({tag, "_pulses"}, 64'({ba_ack, ba_rdy, prog_ack, prog_rdy, tout_err}), 64'd0);
  endtask

  task automatic randomize_data();
    prog_addr = AW'($urandom); prog_ba = 2'($urandom);
    prog_data = 16'($urandom); prog_mask = 2'($urandom);
    ba0_addr = AW'($urandom); ba1_addr = AW'($urandom);
    ba2_addr = AW'($urandom); ba3_addr = AW'($urandom);
    ba0_din = 16'($urandom); ba0_din_m = 2'($urandom);
  endtask

  // Engine model: acks after m_ack_dly cycles, completes m_done_dly cycles later, or hangs.
  initial begin : engine
    int st;
    int cnt;
    st = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      cmd_ack = 1'b0; cmd_done = 1'b0;
      if (rst) st = 0;
      else begin
        if (st == 0 && cmd_req) begin st = 1; cnt = m_ack_dly; end
        if (st == 1) begin
          if (cnt == 0) begin
            cmd_ack = 1'b1;
            if (m_sim) begin cmd_done = 1'b1; st = 0; end
            else if (m_hang) st = 3;
            else begin st = 2; cnt = m_done_dly; end
          end else cnt--;
        end else if (st == 2) begin
          if (cnt == 0) begin cmd_done = 1'b1; st = 0; end
          else cnt--;
        end else if (st == 3) begin
          if (tout_err) st = 0;
        end
      end
    end
  end

  initial begin : monitor
    txn_t       e;
    txn_t       cur;
    logic       req_prev;
    logic [4:0] ackv;
    logic [5:0] rdyv;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) req_prev = 1'b0;
      else begin
        if (cmd_req && !req_prev) begin
          if (exp_q.size() == 0) chk("cmd_unexpected", 64'(cmd_req), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("cmd_ba", 64'(cmd_ba), 64'(e.ba));
            chk("cmd_addr", 64'(cmd_addr), 64'(e.addr));
            chk("cmd_wr", 64'(cmd_wr), 64'(e.wr));
            if (e.wr) begin
              chk("cmd_din", 64'(cmd_din), 64'(e.din));
              chk("cmd_mask", 64'(cmd_mask), 64'(e.mask));
            end
            cur = e;
            act_q.push_back(e);
          end
        end else if (cmd_req && req_prev) begin
          chk("cmd_hold", 64'({cmd_ba, cmd_addr}), 64'({cur.ba, cur.addr}));
        end
        req_prev = cmd_req;

        ackv = {prog_ack, ba_ack};
        if (ackv != '0) begin
          if (act_q.size() == 0) chk("ack_unexpected", 64'(ackv), 64'd0);
          else begin
            e = act_q.pop_front();
            chk("ack_owner", 64'(ackv), 64'(5'b00001 << e.owner));
            e.ack_cyc = cyc;
            done_q.push_back(e);
          end
        end

        rdyv = {tout_err, prog_rdy, ba_rdy};
        if (rdyv != '0) begin
          if (done_q.size() == 0) chk("rdy_unexpected", 64'(rdyv), 64'd0);
          else begin
            e = done_q.pop_front();
            chk("rdy_owner", 64'(rdyv), e.tout ? 64'h20 : 64'(6'b000001 << e.owner));
            if (e.tout) chk("tout_delay", 64'(cyc - e.ack_cyc), 64'(TOUT));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1;
    downloading = 1'b0;
    clear_lines();
    randomize_data();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    flush_model();
    @(posedge clk); #1;

    // Single bank-2 read with a slow engine.
    ba2_addr = 22'h2A5A5;
    ba_rd = 4'b0100;
    set_engine(2, 4, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b1);
    wait_idle();

    // All banks held, zero-wait engine, eight grants.
    ba_rd = 4'hF;
    set_engine(0, 0, 1'b0, 1'b0);
    serve(8, 1'b1, 1'b1);
    wait_idle();

    // Bank-0 write alongside bank-0 read.
    ba0_din = 16'hA55A; ba0_din_m = 2'b01;
    ba_rd = 4'b0001; ba_wr = 1'b1;
    serve(4, 1'b0, 1'b1);
    wait_idle();

    // Download filter, then drop downloading while the prog write is in WAIT.
    rst = 1'b1; flush_model();
    @(posedge clk); #1;
    rst = 1'b0;
    downloading = 1'b1; prog_we = 1'b1; prog_ba = 2'b11;
    ba_rd = 4'b0011;
    set_engine(0, 4, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b1);
    downloading = 1'b0;
    serve(8, 1'b0, 1'b0);
    wait_idle();

    // Watchdog on a hung engine, then the pending request still gets served.
    ba_rd = 4'b1001;
    set_engine(0, 0, 1'b0, 1'b1);
    serve(1, 1'b0, 1'b1);
    set_engine(0, 1, 1'b0, 1'b0);
    serve(4, 1'b0, 1'b0);
    wait_idle();

    // Reset while waiting for completion.
    ba1_addr = 22'h155555;
    ba_rd = 4'b0010;
    set_engine(0, 6, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_wait");
    flush_model();
    clear_lines();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ba_rd = 4'b1001;
    set_engine(0, 0, 1'b0, 1'b0);
    serve(4, 1'b0, 1'b1);
    wait_idle();

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      randomize_data();
      downloading = ($urandom_range(3) == 0);
      ba_rd = 4'($urandom);
      ba_wr = ($urandom_range(2) == 0);
      prog_rd = 1'($urandom_range(1));
      prog_we = 1'($urandom_range(1));
      m_ack_dly = int'($urandom_range(2));
      m_done_dly = int'($urandom_range(3));
      m_sim = ($urandom_range(4) == 0);
      m_hang = !m_sim && ($urandom_range(9) == 0);
      serve(16, 1'b0, 1'b1);
      wait_idle();
      clear_lines();
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
